// File: rtl/control_pkg.sv
// Shared opcodes, state encoding, datapath select codes and trap codes for control_multi.
package control_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_R    = 6'd0;
    localparam logic [OP_W-1:0] OP_J    = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL  = 6'd3;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd8;
    localparam logic [OP_W-1:0] OP_LW   = 6'd35;
    localparam logic [OP_W-1:0] OP_SW   = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_RWB, S_BRANCH, S_JUMP, S_JAL, S_ADDIEX, S_ADDIWB, S_ERR
    } state_e;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Control word driven onto the multi-cycle datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic       link;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that wait on the memory handshake
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-memory-state wait counter: gates mem_ready by a minimum wait and flags a timeout.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_state_i,
    input  logic clear_i,
    input  logic mem_ready_i,
    output logic accept_c_o,
    output logic timeout_c_o
);

    localparam int unsigned MAX_V = (MEM_WAIT > TIMEOUT) ? MEM_WAIT : TIMEOUT;
    localparam int unsigned CW    = $clog2(MAX_V + 2);
    localparam bit          TO_EN = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   cnt_p1;

    // Count cycles spent in the current memory state, saturating; restart on any state change
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (mem_state_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_p1      = 32'(cnt_q) + 32'd1;
    assign accept_c_o  = mem_state_i & mem_ready_i & (cnt_p1 > MEM_WAIT);
    assign timeout_c_o = TO_EN & mem_state_i & (cnt_p1 == TIMEOUT);

endmodule

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM with memory handshake, retire counter and sticky trap.
// Build option: define CTRL_ADDI_EN to make opcode 8 (ADDI) legal; otherwise it traps as illegal.
module control_multi
    import control_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic             Link,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [CNT_W-1:0] retired,
    output logic             trap,
    output logic [1:0]       trap_code
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             trap_q, trap_d;
    logic [1:0]       trap_code_q, trap_code_d;
    ctrl_t            ctrl_c;
    logic [OP_W-1:0]  opcode;
    logic             mem_accept_c, timeout_c;

    assign opcode = instr[31:26];

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_state_i (is_mem_state(state_q)),
        .clear_i     (state_d != state_q),
        .mem_ready_i (mem_ready),
        .accept_c_o  (mem_accept_c),
        .timeout_c_o (timeout_c)
    );

    // Next state, trap/retire bookkeeping and Moore control decode
    always_comb begin
        state_d     = state_q;
        trap_d      = trap_q;
        trap_code_d = trap_code_q;
        retired_d   = retired_q;
        ctrl_c      = '0;

        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = ALUB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_source = PCSRC_ALU;
                ctrl_c.pc_write  = mem_accept_c;
                ctrl_c.ir_write  = mem_accept_c;
                if (mem_accept_c) begin
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d     = S_ERR;
                    trap_code_d = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = ALUB_IMMSH;
                if (instr == '0) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:            state_d = S_EXEC;
                        OP_LW, OP_SW:    state_d = S_MEMADR;
                        OP_BEQ:          state_d = S_BRANCH;
                        OP_J:            state_d = S_JUMP;
                        OP_JAL:          state_d = S_JAL;
`ifdef CTRL_ADDI_EN
                        OP_ADDI:         state_d = S_ADDIEX;
`endif
                        default: begin
                            state_d     = S_ERR;
                            trap_code_d = TRAP_ILLEGAL;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_IMM;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
                if (mem_accept_c) begin
                    state_d = S_MEMWB;
                end else if (timeout_c) begin
                    state_d     = S_ERR;
                    trap_code_d = TRAP_TIMEOUT;
                end
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                if (mem_accept_c) begin
                    state_d = S_FETCH;
                end else if (timeout_c) begin
                    state_d     = S_ERR;
                    trap_code_d = TRAP_TIMEOUT;
                end
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_REG;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.link      = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write = 1'b1;
                state_d = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d     = S_ERR;
                trap_code_d = TRAP_ILLEGAL;
            end
        endcase

        if (state_d == S_ERR) trap_d = 1'b1;
        if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_ERR)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, retire counter and trap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            retired_q   <= '0;
            trap_q      <= 1'b0;
            trap_code_q <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            retired_q   <= retired_d;
            trap_q      <= trap_d;
            trap_code_q <= trap_code_d;
        end
    end

    assign PCWrite     = ctrl_c.pc_write;
    assign PCWriteCond = ctrl_c.pc_write_cond;
    assign IorD        = ctrl_c.i_or_d;
    assign MemRead     = ctrl_c.mem_read;
    assign MemWrite    = ctrl_c.mem_write;
    assign IRWrite     = ctrl_c.ir_write;
    assign MemtoReg    = ctrl_c.mem_to_reg;
    assign RegWrite    = ctrl_c.reg_write;
    assign RegDst      = ctrl_c.reg_dst;
    assign ALUSrcA     = ctrl_c.alu_src_a;
    assign Link        = ctrl_c.link;
    assign ALUSrcB     = ctrl_c.alu_src_b;
    assign ALUOp       = ctrl_c.alu_op;
    assign PCSource    = ctrl_c.pc_source;
    assign retired     = retired_q;
    assign trap        = trap_q;
    assign trap_code   = trap_code_q;

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: instruction-level reference model driving per-cycle expectations.
module tb_control_multi;

    localparam int unsigned MEM_WAIT = 2;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned CNT_W    = 4;
`ifdef CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      instr = '0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegWrite, RegDst, ALUSrcA, Link;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [CNT_W-1:0] retired;
    logic             trap;
    logic [1:0]       trap_code;

    int          total = 0;
    int          bad   = 0;
    int          model_ret = 0;
    logic [31:0] cur_instr = '0;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rdst, asa, link;
        logic [1:0] asb, aop, psrc;
    } tb_ctl_t;

    tb_ctl_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegWrite, RegDst, ALUSrcA, Link, ALUSrcB, ALUOp, PCSource};

    control_multi #(.MEM_WAIT(MEM_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .Link(Link), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .retired(retired), .trap(trap), .trap_code(trap_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Control word each instruction phase should present
    function automatic tb_ctl_t exp_ctrl(input string ph, input logic acc);
        tb_ctl_t c = '0;
        case (ph)
            "FETCH":  begin c.mr = 1; c.asb = 2'b01; c.pcw = acc; c.irw = acc; end
            "DECODE": begin c.asb = 2'b11; end
            "MEMADR": begin c.asa = 1; c.asb = 2'b10; end
            "MEMRD":  begin c.mr = 1; c.iord = 1; end
            "MEMWB":  begin c.rw = 1; c.m2r = 1; end
            "MEMWR":  begin c.mw = 1; c.iord = 1; end
            "EXEC":   begin c.asa = 1; c.aop = 2'b10; end
            "RWB":    begin c.rw = 1; c.rdst = 1; end
            "BRANCH": begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.psrc = 2'b01; end
            "JUMP":   begin c.pcw = 1; c.psrc = 2'b10; end
            "JAL":    begin c.pcw = 1; c.psrc = 2'b10; c.rw = 1; c.link = 1; end
            "ADDIEX": begin c.asa = 1; c.asb = 2'b10; end
            "ADDIWB": begin c.rw = 1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One clock of a phase; k = cycles already spent in this phase
    task automatic one_cycle(input string ph, input logic rdy, input int k, output logic acc);
        logic is_mem;
        @(negedge clk);
        instr = cur_instr;
        mem_ready = rdy;
        #1;
        is_mem = (ph == "FETCH") || (ph == "MEMRD") || (ph == "MEMWR");
        acc = is_mem && rdy && (k >= int'(MEM_WAIT));
        chk({ph, " ctrl"}, 32'(obs), 32'(exp_ctrl(ph, acc)));
        chk({ph, " trap"}, {29'd0, trap, trap_code}, 32'd0);
        chk({ph, " retired"}, 32'(retired), 32'(model_ret));
    endtask

    // Assert reset just after a negedge, check FETCH/reset values, release before next negedge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk({tag, " ctrl"}, 32'(obs), 32'(exp_ctrl("FETCH", 1'b0)));
        chk({tag, " trap"}, {29'd0, trap, trap_code}, 32'd0);
        chk({tag, " retired"}, 32'(retired), 32'd0);
        model_ret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_err(input logic [1:0] code);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #1;
            chk("ERR ctrl", 32'(obs), 32'd0);
            chk("ERR trap", 32'(trap), 32'd1);
            chk("ERR code", 32'(trap_code), 32'(code));
            chk("ERR retired", 32'(retired), 32'(model_ret));
        end
        @(negedge clk);
        #1;
        do_reset("reset after trap");
    endtask

    // res: 0 accepted, 1 timed out, 2 aborted by reset
    task automatic mem_phase(input string ph, input int mode, input int abort_at,
                             inout int lat, output int res);
        logic acc;
        res = 1;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            if (k == abort_at) begin
                @(negedge clk);
                mem_ready = 1'b0;
                #1;
                chk({ph, " pre-reset"}, 32'(obs), 32'(exp_ctrl(ph, 1'b0)));
                do_reset("reset mid-op");
                res = 2;
                return;
            end
            one_cycle(ph, pick(mode), k, acc);
            lat++;
            if (acc) begin
                res = 0;
                return;
            end
        end
    endtask

    task automatic simple(input string ph, input int mode, inout int lat);
        logic acc;
        one_cycle(ph, pick(mode), 0, acc);
        lat++;
    endtask

    // Run one instruction through the model; lat = -1 when it traps or is aborted
    task automatic run_instr(input logic [31:0] ins, input int fmode, input int mmode,
                             input int abort_at, output int lat);
        int         res;
        logic [5:0] op;
        cur_instr = ins;
        op = ins[31:26];
        lat = 0;
        mem_phase("FETCH", fmode, -1, lat, res);
        if (res == 1) begin check_err(2'b10); lat = -1; return; end
        simple("DECODE", fmode, lat);
        if (ins == 32'd0) begin
        end else if (op == 6'd0) begin
            simple("EXEC", fmode, lat);
            simple("RWB", fmode, lat);
        end else if (op == 6'd35) begin
            simple("MEMADR", fmode, lat);
            mem_phase("MEMRD", mmode, abort_at, lat, res);
            if (res == 1) begin check_err(2'b10); lat = -1; return; end
            if (res == 2) begin lat = -1; return; end
            simple("MEMWB", fmode, lat);
        end else if (op == 6'd43) begin
            simple("MEMADR", fmode, lat);
            mem_phase("MEMWR", mmode, abort_at, lat, res);
            if (res == 1) begin check_err(2'b10); lat = -1; return; end
            if (res == 2) begin lat = -1; return; end
        end else if (op == 6'd4) begin
            simple("BRANCH", fmode, lat);
        end else if (op == 6'd2) begin
            simple("JUMP", fmode, lat);
        end else if (op == 6'd3) begin
            simple("JAL", fmode, lat);
        end else if (op == 6'd8 && ADDI_EN) begin
            simple("ADDIEX", fmode, lat);
            simple("ADDIWB", fmode, lat);
        end else begin
            check_err(2'b01);
            lat = -1;
            return;
        end
        model_ret = (model_ret + 1) % (1 << CNT_W);
    endtask

    initial begin
        int lat;
        logic [5:0] pool [8];
        pool = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd8, 6'd0};

        @(negedge clk);
        #1;
        do_reset("reset");

        run_instr(32'h012A_4020, 1, 1, -1, lat);  chk("lat R", 32'(lat), 32'd6);
        run_instr(32'h8D09_0004, 1, 1, -1, lat);  chk("lat LW", 32'(lat), 32'd9);
        run_instr(32'hAD09_0008, 1, 1, -1, lat);  chk("lat SW", 32'(lat), 32'd8);
        run_instr(32'h1109_0003, 1, 1, -1, lat);  chk("lat BEQ", 32'(lat), 32'd5);
        run_instr(32'h0800_0010, 1, 1, -1, lat);  chk("lat J", 32'(lat), 32'd5);
        run_instr(32'h0C00_0020, 1, 1, -1, lat);  chk("lat JAL", 32'(lat), 32'd5);
        run_instr(32'h0000_0000, 1, 1, -1, lat);  chk("lat NOP", 32'(lat), 32'd4);
        run_instr(32'h2108_0005, 1, 1, -1, lat);
        chk("lat ADDI", 32'(lat), ADDI_EN ? 32'd6 : 32'hFFFF_FFFF);

        // Store whose memory never answers
        run_instr(32'hAD09_000C, 1, 2, -1, lat);  chk("SW timeout", 32'(lat), 32'hFFFF_FFFF);
        // Fetch that never answers
        run_instr(32'h012A_4020, 2, 1, -1, lat);  chk("FETCH timeout", 32'(lat), 32'hFFFF_FFFF);
        // Illegal opcode
        run_instr(32'hFC00_0000, 1, 1, -1, lat);  chk("illegal", 32'(lat), 32'hFFFF_FFFF);

        // Sixteen NOPs wrap the 4-bit retire counter
        for (int i = 0; i < 16; i++) begin
            run_instr(32'd0, 1, 1, -1, lat);
            chk("lat NOP wrap", 32'(lat), 32'd4);
        end
        @(negedge clk);
        #1;
        chk("retired wrap", 32'(retired), 32'd0);
        do_reset("reset after wrap");

        // Retire a few, then reset in the middle of a stalled store
        run_instr(32'h012A_4020, 1, 1, -1, lat);
        run_instr(32'hAD09_0010, 1, 2, 5, lat);   chk("SW abort", 32'(lat), 32'hFFFF_FFFF);

        // Random instruction mix with random memory readiness
        for (int n = 0; n < 80; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) == 0)      ins = 32'd0;
            else if ($urandom_range(0, 5) == 0) ins[31:26] = 6'($urandom);
            else                                ins[31:26] = pool[$urandom_range(0, 7)];
            run_instr(ins, 0, 0, -1, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
